// File: rtl/mult_share_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_sched_if
// Purpose  : Requester-side bundle for the shared multiplier scheduler.
//            Carries the request/operand lines toward the scheduler and the
//            grant and response pulses back to the requesters.
// Ports    : req        - level request per requester
//            req_a/b    - packed operands, slice i = [i*W +: W]
//            gnt        - one-hot operand-capture pulse
//            rsp_valid  - one-hot response pulse
//            rsp_data   - product (upper W bits), 0 on error
//            rsp_err    - timeout flag, qualified by rsp_valid
// Revision : 1.0 - initial release
// ============================================================================
interface mult_share_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_err;

  // Requester side
  modport master (
    output req, req_a, req_b,
    input  gnt, rsp_valid, rsp_data, rsp_err
  );

  // Scheduler side
  modport slave (
    input  req, req_a, req_b,
    output gnt, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mult_share_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_sched
// Purpose  : Time-shares one iterative multiplier (start pulse, level done)
//            among NREQ requesters with round-robin arbitration. Operands
//            are captured in the grant cycle, a guard cycle masks the stale
//            done level left over from the previous operation, and a
//            watchdog returns an error response if done never rises.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            en              - 1 allows new grants; in-flight op always ends
//            req_bus         - requester bundle (slave side)
//            busy            - 1 whenever the FSM is not idle
//            mult_start      - one-cycle start pulse to the multiplier
//            mult_a/mult_b   - operands, held from start until next grant
//            mult_done       - multiplier done level
//            mult_product    - multiplier result, valid while done is high
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          en,
  mult_share_sched_if.slave  req_bus,
  output logic               busy,
  output logic               mult_start,
  output logic [W-1:0]       mult_a,
  output logic [W-1:0]       mult_b,
  input  wire logic          mult_done,
  input  wire logic [W-1:0]  mult_product
);

  localparam int c_idx_w = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_cnt_w = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GUARD = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t               r_state,     nxt_state;
  logic [c_idx_w-1:0]   r_ptr,       nxt_ptr;
  logic [c_idx_w-1:0]   r_owner,     nxt_owner;
  logic [c_cnt_w-1:0]   r_cnt,       nxt_cnt;
  logic [NREQ-1:0]      r_gnt,       nxt_gnt;
  logic [NREQ-1:0]      r_rsp_valid, nxt_rsp_valid;
  logic [W-1:0]         r_rsp_data,  nxt_rsp_data;
  logic                 r_rsp_err,   nxt_rsp_err;
  logic                 r_busy,      nxt_busy;
  logic                 r_start,     nxt_start;
  logic [W-1:0]         r_a,         nxt_a;
  logic [W-1:0]         r_b,         nxt_b;

  logic                 w_found;
  logic [c_idx_w-1:0]   w_win;

  // Round-robin search: first pending request strictly after the pointer,
  // so the last-served requester is considered last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_bus.req[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = c_idx_w'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    nxt_state     = r_state;
    nxt_ptr       = r_ptr;
    nxt_owner     = r_owner;
    nxt_cnt       = r_cnt;
    nxt_gnt       = '0;
    nxt_rsp_valid = '0;
    nxt_rsp_data  = r_rsp_data;
    nxt_rsp_err   = r_rsp_err;
    nxt_start     = 1'b0;
    nxt_a         = r_a;
    nxt_b         = r_b;

    case (r_state)
      S_IDLE: begin
        if (en && w_found) begin
          nxt_state      = S_ISSUE;
          nxt_gnt[w_win] = 1'b1;
          nxt_start      = 1'b1;
          nxt_a          = req_bus.req_a[int'(w_win)*W +: W];
          nxt_b          = req_bus.req_b[int'(w_win)*W +: W];
          nxt_owner      = w_win;
        end
      end
      S_ISSUE: nxt_state = S_GUARD;
      // Done may still be high from the previous product here; ignore it.
      S_GUARD: begin
        nxt_state = S_WAIT;
        nxt_cnt   = '0;
      end
      S_WAIT: begin
        if (mult_done) begin
          nxt_state              = S_RESP;
          nxt_rsp_valid[r_owner] = 1'b1;
          nxt_rsp_data           = mult_product;
          nxt_rsp_err            = 1'b0;
        end else if (r_cnt == c_cnt_w'(TIMEOUT - 1)) begin
          nxt_state              = S_RESP;
          nxt_rsp_valid[r_owner] = 1'b1;
          nxt_rsp_data           = '0;
          nxt_rsp_err            = 1'b1;
        end else begin
          nxt_cnt = r_cnt + 1'b1;
        end
      end
      S_RESP: begin
        nxt_state = S_IDLE;
        nxt_ptr   = r_owner;
      end
      default: nxt_state = S_IDLE;
    endcase

    nxt_busy = (nxt_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= c_idx_w'(NREQ - 1);
      r_owner     <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
    end else begin
      r_state     <= nxt_state;
      r_ptr       <= nxt_ptr;
      r_owner     <= nxt_owner;
      r_cnt       <= nxt_cnt;
      r_gnt       <= nxt_gnt;
      r_rsp_valid <= nxt_rsp_valid;
      r_rsp_data  <= nxt_rsp_data;
      r_rsp_err   <= nxt_rsp_err;
      r_busy      <= nxt_busy;
      r_start     <= nxt_start;
      r_a         <= nxt_a;
      r_b         <= nxt_b;
    end
  end

  assign req_bus.gnt       = r_gnt;
  assign req_bus.rsp_valid = r_rsp_valid;
  assign req_bus.rsp_data  = r_rsp_data;
  assign req_bus.rsp_err   = r_rsp_err;
  assign busy              = r_busy;
  assign mult_start        = r_start;
  assign mult_a            = r_a;
  assign mult_b            = r_b;

endmodule
`default_nettype wire
